// File: rtl/sevenseg_scan_capture.sv
// Samples a multiplexed 7-segment scan, decodes each digit back to a symbol and
// releases a 4-digit frame over valid/ready after it repeats MATCH_FRAMES times.
module sevenseg_scan_capture #(
   parameter int SETTLE       = 4,
   parameter int MATCH_FRAMES = 2,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic        CLK_in,
   input  logic        RST_in,
   input  logic [3:0]  led_active,
   input  logic [7:0]  led_code,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic [15:0] frame_digits,
   output logic [3:0]  frame_dp,
   output logic        bad_glyph,
   output logic        overrun
);

   logic [3:0]  act_in, act_r, act_p;
   logic [7:0]  code_in, code_r, code_p;
   logic [7:0]  settle_cnt, settle_nx;
   logic [3:0]  mask;
   logic [15:0] slot_dig;
   logic [3:0]  slot_dp;
   logic [19:0] prev_frame;
   logic [3:0]  match_cnt, match_nx;
   logic        one_hot, held, sample, complete, same, rel, take;
   logic [4:0]  dec;

   // Returns {bad, symbol}; bad patterns map to symbol B.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'h3F:   r = 5'h00;
         7'h06:   r = 5'h01;
         7'h5B:   r = 5'h02;
         7'h4F:   r = 5'h03;
         7'h66:   r = 5'h04;
         7'h6D:   r = 5'h05;
         7'h7D:   r = 5'h06;
         7'h07:   r = 5'h07;
         7'h7F:   r = 5'h08;
         7'h6F:   r = 5'h09;
         7'h40:   r = 5'h0A;
         7'h50:   r = 5'h0C;
         7'h79:   r = 5'h0E;
         7'h00:   r = 5'h0F;
         default: r = 5'h1B;
      endcase
      return r;
   endfunction

   assign act_in  = ACTIVE_LOW ? ~led_active : led_active;
   assign code_in = ACTIVE_LOW ? ~led_code   : led_code;

   always_comb begin
      one_hot  = (act_r != 4'd0) && ((act_r & (act_r - 4'd1)) == 4'd0);
      held     = (act_r == act_p) && (code_r == code_p);
      // Counts cycles the current select/code has been held, so a digit shown
      // for SETTLE cycles is sampled; blanking holds the count at zero.
      settle_nx = 8'd0;
      if (one_hot) begin
         if (!held)
            settle_nx = 8'd1;
         else if (settle_cnt != 8'hFF)
            settle_nx = settle_cnt + 8'd1;
         else
            settle_nx = settle_cnt;
      end
      sample   = one_hot && (settle_nx == 8'(SETTLE)) && ((mask & act_r) == 4'd0);
      dec      = decode(code_r[6:0]);
      complete = (mask == 4'hF);
      same     = ({slot_dig, slot_dp} == prev_frame);
      match_nx = 4'd1;
      if (same)
         match_nx = (match_cnt == 4'hF) ? 4'hF : match_cnt + 4'd1;
      // Saturated repeats keep match_nx equal to match_cnt and must not re-release.
      rel  = complete && (match_nx == 4'(MATCH_FRAMES)) && !(same && (match_cnt == match_nx));
      take = frame_valid && frame_ready;
   end

   always_ff @(posedge CLK_in) begin
      if (RST_in) begin
         act_r        <= 4'd0;
         act_p        <= 4'd0;
         code_r       <= 8'd0;
         code_p       <= 8'd0;
         settle_cnt   <= 8'd0;
         mask         <= 4'd0;
         slot_dig     <= 16'd0;
         slot_dp      <= 4'd0;
         prev_frame   <= 20'd0;
         match_cnt    <= 4'd0;
         frame_valid  <= 1'b0;
         frame_digits <= 16'd0;
         frame_dp     <= 4'd0;
         bad_glyph    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         act_r      <= act_in;
         code_r     <= code_in;
         act_p      <= act_r;
         code_p     <= code_r;
         settle_cnt <= settle_nx;

         mask <= (complete ? 4'd0 : mask) | (sample ? act_r : 4'd0);
         for (int i = 0; i < 4; i++) begin
            if (sample && act_r[i]) begin
               slot_dig[i*4 +: 4] <= dec[3:0];
               slot_dp[i]         <= code_r[7];
            end
         end
         if (sample && dec[4])
            bad_glyph <= 1'b1;

         if (complete) begin
            match_cnt <= match_nx;
            if (!same)
               prev_frame <= {slot_dig, slot_dp};
         end

         if (rel && (!frame_valid || take)) begin
            frame_valid  <= 1'b1;
            frame_digits <= slot_dig;
            frame_dp     <= slot_dp;
         end else if (rel) begin
            overrun <= 1'b1;
         end else if (take) begin
            frame_valid <= 1'b0;
         end
      end
   end

endmodule
